// File: rtl/led_scan_if.sv
// led_scan_if: frame handshake and row-scan display signals between producer, controller and LED array.
// LED_SCAN_BRIGHTNESS_EN adds the brightness control signal.
interface led_scan_if;
    logic [35:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [35:0] frame_out;
    logic [3:0]  COUNT;
    logic        blank;
    logic        frame_start;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0]  brightness;
    modport master (output frame_in, frame_valid, brightness,
                    input  frame_ready, frame_out, COUNT, blank, frame_start);
    modport slave  (input  frame_in, frame_valid, brightness,
                    output frame_ready, frame_out, COUNT, blank, frame_start);
`else
    modport master (output frame_in, frame_valid,
                    input  frame_ready, frame_out, COUNT, blank, frame_start);
    modport slave  (input  frame_in, frame_valid,
                    output frame_ready, frame_out, COUNT, blank, frame_start);
`endif
endinterface

// File: rtl/led_scan_controller.sv
// led_scan_controller: 8-row LED scan scheduler with blanking and frame-boundary double buffering.
// LED_SCAN_BRIGHTNESS_EN adds PWM dimming of each row's dwell.
module led_scan_controller #(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input logic      CLOCK,
    input logic      RESET,
    led_scan_if.slave bus
);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    count_q, count_d;
    logic [35:0]   frame_out_q, frame_out_d;
    logic [35:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic          frame_start_q, frame_start_d;
    logic          row_end, blank_end, boundary, accept, dim;

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0] bright_q, bright_d;
    logic [31:0] lim;
    assign bright_d = blank_end ? bus.brightness : bright_q;
    assign lim      = ((32'(bright_q) + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
    assign dim      = 32'(cnt_q) >= lim;
    always_ff @(posedge CLOCK or negedge RESET)
        if (!RESET) bright_q <= '0;
        else        bright_q <= bright_d;
`else
    assign dim = 1'b0;
`endif

    always_comb begin
        row_end       = (state_q == DRIVE) && (cnt_q == CW'(DWELL_CYCLES - 1));
        blank_end     = (state_q == BLANK) && (cnt_q == CW'(BLANK_CYCLES - 1));
        boundary      = row_end && (count_q == 3'd7);
        accept        = bus.frame_valid && !pend_full_q;
        state_d       = row_end ? BLANK : blank_end ? DRIVE : state_q;
        cnt_d         = (row_end || blank_end) ? '0 : cnt_q + CW'(1);
        count_d       = row_end ? count_q + 3'd1 : count_q;
        pend_d        = accept ? bus.frame_in : pend_q;
        // accept needs an empty buffer and swap needs a full one, so they never collide
        pend_full_d   = accept || (pend_full_q && !boundary);
        frame_out_d   = (boundary && pend_full_q) ? pend_q : frame_out_q;
        frame_start_d = boundary;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            count_q       <= '0;
            frame_out_q   <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            frame_out_q   <= frame_out_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.frame_ready = !pend_full_q;
    assign bus.frame_out   = frame_out_q;
    assign bus.COUNT       = {1'b0, count_q};
    assign bus.blank       = (state_q == BLANK) || dim;
    assign bus.frame_start = frame_start_q;
endmodule
